// File: rtl/fsm_lut_pkg.sv
// Shared definitions for the LUT-scheduled FSM block.
// Provides the channel state encoding, table geometry, the power-up table
// contents and a lookup helper that returns the default entry for an index.
package fsm_lut_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam int unsigned LUT_AW    = 3;
    localparam int unsigned LUT_DW    = 3;
    localparam int unsigned LUT_DEPTH = 8;

    localparam int DEF_N_CH = 4;

    // Entry format: {next_state[1:0], z}; index format: {state[1:0], x}
    localparam logic [LUT_DW-1:0] DEF_LUT0 = 3'b000;
    localparam logic [LUT_DW-1:0] DEF_LUT1 = 3'b010;
    localparam logic [LUT_DW-1:0] DEF_LUT2 = 3'b100;
    localparam logic [LUT_DW-1:0] DEF_LUT3 = 3'b010;
    localparam logic [LUT_DW-1:0] DEF_LUT4 = 3'b110;
    localparam logic [LUT_DW-1:0] DEF_LUT5 = 3'b010;
    localparam logic [LUT_DW-1:0] DEF_LUT6 = 3'b001;
    localparam logic [LUT_DW-1:0] DEF_LUT7 = 3'b010;

    function automatic logic [LUT_DW-1:0] def_lut(input logic [LUT_AW-1:0] idx);
        logic [LUT_DW-1:0] val;
        case (idx)
            3'd0:    val = DEF_LUT0;
            3'd1:    val = DEF_LUT1;
            3'd2:    val = DEF_LUT2;
            3'd3:    val = DEF_LUT3;
            3'd4:    val = DEF_LUT4;
            3'd5:    val = DEF_LUT5;
            3'd6:    val = DEF_LUT6;
            default: val = DEF_LUT7;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/fsm_lut_scheduler_if.sv
// Channel handshake bundle for fsm_lut_scheduler.
//   in_valid : per-channel request, channel i presents x_in[i]
//   x_in     : per-channel FSM input bit
//   in_ready : one-hot or zero grant returned by the scheduler
// master = the channel side (requesters), slave = the scheduler.
interface fsm_lut_scheduler_if
    import fsm_lut_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);
    logic [N_CH-1:0] in_valid;
    logic [N_CH-1:0] x_in;
    logic [N_CH-1:0] in_ready;

    modport master (
        output in_valid,
        output x_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  x_in,
        output in_ready
    );
endinterface

// File: rtl/fsm_lut_ram.sv
// 8x3 register file holding the shared next-state/output table.
//   clk, reset : rising-edge clock, synchronous active-high reset (loads defaults)
//   we         : write strobe
//   waddr/wdata: write index and entry
//   raddr      : combinational read index
//   rdata      : combinational read data
module fsm_lut_ram
    import fsm_lut_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [LUT_DW-1:0] wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [LUT_DW-1:0] rdata
);

    logic [LUT_DW-1:0] mem [LUT_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
                mem[i] <= def_lut(LUT_AW'(i));
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fsm_lut_scheduler.sv
// Time-multiplexes one shared 8x3 next-state/output table among N_CH
// independent 2-bit Mealy FSM channels with round-robin arbitration.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   ch_if      : channel handshake (in_valid, x_in in; in_ready out)
//   ch_clr     : per-channel soft clear of state and z_out
//   cfg_we/cfg_addr/cfg_data : table rewrite port, blocks lookups that cycle
//   z_out      : registered Mealy output per channel
//   z_valid    : one-cycle pulse marking the channel whose z_out updated
//   state_out  : current state per channel, channel i at [2i+1:2i]
module fsm_lut_scheduler
    import fsm_lut_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int PTR_W = 2
)(
    input  logic                clk,
    input  logic                reset,
    fsm_lut_scheduler_if.slave  ch_if,
    input  logic [N_CH-1:0]     ch_clr,
    input  logic                cfg_we,
    input  logic [LUT_AW-1:0]   cfg_addr,
    input  logic [LUT_DW-1:0]   cfg_data,
    output logic [N_CH-1:0]     z_out,
    output logic [N_CH-1:0]     z_valid,
    output logic [2*N_CH-1:0]   state_out
);

    state_t             st [N_CH];
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;
    logic               grant_vld;
    logic [N_CH-1:0]    eligible;
    logic [LUT_AW-1:0]  lut_addr;
    logic [LUT_DW-1:0]  lut_rd;

    // A channel being cleared is never granted, so the clear always wins
    assign eligible = ch_if.in_valid & ~ch_clr;

    // Round-robin scan upward from ptr; the first eligible channel wins
    always_comb begin
        grant_vld      = 1'b0;
        grant_idx      = '0;
        cand           = '0;
        ch_if.in_ready = '0;
        if (!reset && !cfg_we) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                cand = PTR_W'((32'(ptr) + k) % 32'(N_CH));
                if (!grant_vld && eligible[cand]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        ch_if.in_ready[grant_idx] = grant_vld;
    end

    assign ptr_nxt  = (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + PTR_W'(1);
    assign lut_addr = {st[grant_idx], ch_if.x_in[grant_idx]};

    fsm_lut_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (lut_addr),
        .rdata (lut_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            z_out   <= '0;
            z_valid <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                st[i] <= S0;
            end
        end else begin
            z_valid <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                if (ch_clr[i]) begin
                    st[i]    <= S0;
                    z_out[i] <= 1'b0;
                end
            end
            if (grant_vld) begin
                st[grant_idx]      <= state_t'(lut_rd[2:1]);
                z_out[grant_idx]   <= lut_rd[0];
                z_valid[grant_idx] <= 1'b1;
                ptr                <= ptr_nxt;
            end
        end
    end

    always_comb begin
        state_out = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_out[2*i +: 2] = st[i];
        end
    end

endmodule

// File: tb/tb_fsm_lut_scheduler.sv
// Randomized + directed bench for fsm_lut_scheduler with a scoreboard.
// The driver predicts every lookup from a table/array reference model and
// queues the expected response; a negedge monitor pops and compares it
// whenever the design pulses z_valid.
module tb_fsm_lut_scheduler;

    localparam int N = 4;

    typedef struct {
        int       tag;
        int       ch;
        bit       z;
        bit [1:0] st;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] ch_clr;
    logic         cfg_we;
    logic [2:0]   cfg_addr;
    logic [2:0]   cfg_data;
    logic [N-1:0] z_out;
    logic [N-1:0] z_valid;
    logic [2*N-1:0] state_out;

    fsm_lut_scheduler_if #(.N_CH(N)) ch_if ();

    fsm_lut_scheduler #(.N_CH(N), .PTR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .ch_if     (ch_if),
        .ch_clr    (ch_clr),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .z_out     (z_out),
        .z_valid   (z_valid),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    // Reference model
    localparam bit [2:0] DEF [8] = '{3'b000, 3'b010, 3'b100, 3'b010,
                                     3'b110, 3'b010, 3'b001, 3'b010};
    bit [2:0] tbl [8];
    bit [1:0] m_st [N];
    bit       m_z [N];
    int       m_ptr;
    int       cyc;
    exp_t     sbq [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 2'b00;
            m_z[i]  = 1'b0;
        end
        m_ptr = 0;
        tbl   = DEF;
    endtask

    // One clock cycle: drive, predict, then check registered outputs after the edge
    task automatic cycle(input bit rst, input bit [N-1:0] v, input bit [N-1:0] x,
                         input bit [N-1:0] clr, input bit we,
                         input bit [2:0] a, input bit [2:0] d);
        int        g;
        bit [2:0]  ent;
        bit [2*N-1:0] exp_st;
        bit [N-1:0]   exp_z;
        exp_t      e;
        reset          = rst;
        ch_if.in_valid = v;
        ch_if.x_in     = x;
        ch_clr         = clr;
        cfg_we         = we;
        cfg_addr       = a;
        cfg_data       = d;
        #2;
        g = -1;
        if (!rst && !we) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && v[idx] && !clr[idx]) g = idx;
            end
        end
        chk("in_ready", ch_if.in_ready, (g < 0) ? 0 : (1 << g));
        if (rst) begin
            model_reset();
        end else begin
            if (we) tbl[a] = d;
            for (int i = 0; i < N; i++) begin
                if (clr[i]) begin
                    m_st[i] = 2'b00;
                    m_z[i]  = 1'b0;
                end
            end
            if (g >= 0) begin
                ent     = tbl[{m_st[g], x[g]}];
                m_st[g] = ent[2:1];
                m_z[g]  = ent[0];
                e.tag = cyc + 1;
                e.ch  = g;
                e.z   = ent[0];
                e.st  = ent[2:1];
                sbq.push_back(e);
                m_ptr = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            exp_st[2*i +: 2] = m_st[i];
            exp_z[i]         = m_z[i];
        end
        chk("state_out", state_out, exp_st);
        chk("z_out", z_out, exp_z);
    endtask

    // Monitor: compares each z_valid pulse against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (z_valid !== '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_z_valid", z_valid, 0);
            end else begin
                e = sbq.pop_front();
                chk("z_valid_cycle", cyc, e.tag);
                chk("z_valid_onehot", z_valid, 1 << e.ch);
                chk("z_out_ch", z_out[e.ch], e.z);
                chk("state_ch", state_out[2*e.ch +: 2], e.st);
            end
        end else if (sbq.size() != 0 && sbq[0].tag <= cyc) begin
            e = sbq.pop_front();
            chk("missing_z_valid", z_valid, 1 << e.ch);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0;
        model_reset();
        reset = 1'b1;
        ch_if.in_valid = '0;
        ch_if.x_in = '0;
        ch_clr = '0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        #1;

        // Reset
        cycle(1, 4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 3'd0);
        cycle(1, 4'b1111, 4'b1111, 4'b0000, 0, 3'd0, 3'd0);
        chk("reset_state", state_out, 0);
        chk("reset_z_valid", z_valid, 0);

        // Test 1: ch0 x=1 from 00 -> state 01, z 0
        cycle(0, 4'b0001, 4'b0001, 4'b0000, 0, 3'd0, 3'd0);
        chk("t1_state0", state_out[1:0], 2'b01);
        chk("t1_z0", z_out[0], 0);
        chk("t1_z_valid", z_valid, 4'b0001);

        // Test 2: walk 01 -> 10 -> 11 -> 00 with z=1 on the last step
        cycle(0, 4'b0001, 4'b0000, 4'b0000, 0, 3'd0, 3'd0);
        chk("t2_state10", state_out[1:0], 2'b10);
        cycle(0, 4'b0001, 4'b0000, 4'b0000, 0, 3'd0, 3'd0);
        chk("t2_state11", state_out[1:0], 2'b11);
        cycle(0, 4'b0001, 4'b0000, 4'b0000, 0, 3'd0, 3'd0);
        chk("t2_state00", state_out[1:0], 2'b00);
        chk("t2_z1", z_out[0], 1);
        cycle(0, 4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 3'd0);
        chk("t2_pulse_end", z_valid, 0);
        chk("t2_z_hold", z_out[0], 1);

        // Test 3: all channels valid, then drop ch2
        for (int i = 0; i < 8; i++)
            cycle(0, 4'b1111, 4'($urandom_range(0, 15)), 4'b0000, 0, 3'd0, 3'd0);
        for (int i = 0; i < 4; i++)
            cycle(0, 4'b1011, 4'($urandom_range(0, 15)), 4'b0000, 0, 3'd0, 3'd0);

        // Test 4: cfg write blocks lookups; ch0 cleared in the same cycle
        cycle(0, 4'b0001, 4'b0001, 4'b0001, 1, 3'd1, 3'b111);
        chk("t4_clr_state", state_out[1:0], 2'b00);
        chk("t4_no_pulse", z_valid, 0);
        cycle(0, 4'b0001, 4'b0001, 4'b0000, 0, 3'd0, 3'd0);
        chk("t4_state11", state_out[1:0], 2'b11);
        chk("t4_z1", z_out[0], 1);

        // Test 5: ptr=1, ch1 cleared while valid -> ch2 granted
        cycle(0, 4'b0110, 4'b0110, 4'b0010, 0, 3'd0, 3'd0);
        chk("t5_ch1_state", state_out[3:2], 2'b00);
        chk("t5_ch1_z", z_out[1], 0);
        chk("t5_grant_ch2", z_valid, 4'b0100);

        // Test 6: reset during a granted cycle restores the default table
        cycle(0, 4'b0000, 4'b0000, 4'b0000, 1, 3'd5, 3'b101);
        cycle(1, 4'b1111, 4'b1111, 4'b0000, 0, 3'd0, 3'd0);
        chk("t6_z_valid", z_valid, 0);
        chk("t6_states", state_out, 0);
        cycle(0, 4'b0001, 4'b0001, 4'b0000, 0, 3'd0, 3'd0);
        chk("t6_state01", state_out[1:0], 2'b01);
        chk("t6_z0", z_out[0], 0);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            bit [N-1:0] clr;
            clr = '0;
            for (int c = 0; c < N; c++) clr[c] = ($urandom_range(0, 7) == 0);
            cycle(($urandom_range(0, 49) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), clr,
                  ($urandom_range(0, 9) == 0),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        cycle(0, 4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 3'd0);
        cycle(0, 4'b0000, 4'b0000, 4'b0000, 0, 3'd0, 3'd0);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_lut_scheduler.md
Name: fsm_lut_scheduler

Overview:
Time-multiplexes one shared 8x3 next-state/output lookup table among N_CH independent 2-bit Mealy FSM channels.
- Each channel keeps its own state register and presents one input bit per transaction through a valid/ready handshake.
- A round-robin arbiter grants at most one channel per cycle.
- A configuration port rewrites table entries at run time. A cfg write has priority over lookups.

Parameters:
N_CH, 4, number of FSM channels sharing the table (2..8)
PTR_W, 2, width of round-robin pointer; must equal clog2(N_CH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  N_CH  channel i presents x_in[i]
x_in  input  N_CH  FSM input bit per channel
in_ready  output  N_CH  one-hot or zero; channel i granted this cycle
ch_clr  input  N_CH  per-channel soft clear of state to 2'b00
cfg_we  input  1  table write strobe
cfg_addr  input  3  table index {state[1:0], x}
cfg_data  input  3  entry {next_state[1:0], z}
z_out  output  N_CH  registered Mealy output per channel
z_valid  output  N_CH  one-cycle pulse: z_out[i] updated
state_out  output  2*N_CH  current state per channel, channel i at [2i+1:2i]

Behaviour:
- Reset (reset=1 at posedge):
  - All channel states become 2'b00.
  - z_out=0, z_valid=0, round-robin pointer=0.
  - Table loads its defaults: entry0..7 = 000,010,100,010,110,010,001,010.
  - in_ready is combinationally 0 while reset=1.
- Table entry format: data[2:1]=next_state, data[0]=z. Address is {state_i, x_in[i]}. The read is combinational.
- Arbitration (combinational, cycle t):
  - eligible[i] = in_valid[i] & ~ch_clr[i].
  - If cfg_we=1, in_ready=0 for all channels.
  - Otherwise, grant the first eligible channel scanning upward from ptr, with wrap-around modulo N_CH.
  - in_ready[g]=1 only for the granted channel g.
- Transaction completes when in_valid[g] & in_ready[g]. At posedge t+1:
  - state_g <= lut[{state_g, x_in[g]}][2:1]
  - z_out[g] <= lut[...][0]
  - z_valid[g] <= 1
  - ptr <= (g+1) mod N_CH
- Latency: input accepted in cycle t, new state/z visible in cycle t+1. Throughput is 1 lookup/cycle total.
- z_valid for all non-granted channels is 0 in t+1. z_out of non-granted channels holds its value.
- With no grant, ptr holds and all z_valid=0.
- ch_clr[i]=1 at posedge:
  - state_i <= 00 and z_out[i] <= 0.
  - Channel i is never granted that cycle, so the clear wins over a lookup.
  - Other channels are unaffected.
- cfg_we=1 at posedge: lut[cfg_addr] <= cfg_data. No lookup occurs that cycle. A lookup in the next cycle sees the new entry.
- ch_clr and cfg_we in the same cycle: both take effect.
- Fairness: with all channels continuously valid, grants rotate 0,1,..,N_CH-1,0. Each channel waits at most N_CH-1 cycles plus any cfg-write cycles.
- Reset mid-operation: a pending handshake is dropped. No z_valid pulse is produced in the cycle after reset.
- Table rewrites persist until the next reset.

Decomposition:
- Shared package fsm_lut_pkg:
  - State encoding constants S0=2'b00..S3=2'b11.
  - LUT_AW=3, LUT_DW=3.
  - Default table contents, DEF_LUT0..DEF_LUT7.
  - Default N_CH.
- Sub-module fsm_lut_ram:
  - 8x3 register file with combinational read port and synchronous write port.
  - Synchronous reset loads the package defaults.
- The arbiter and per-channel state registers live in the top module.

Test Plan:
1. Reset, then ch0 x=1 from state 00 (entry1=010) -> in_ready[0]=1 in cycle t; in t+1 state_out[1:0]=01, z_out[0]=0, z_valid=0001.
2. ch0 walks x=0 to state 10, then x=0 (entry4=110) -> state 11; then x=0 (entry6=001) -> state 00 with z_out[0]=1 and a one-cycle z_valid[0] pulse.
3. All four channels valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; each z_valid pulse one-hot. Drop ch2 -> order becomes 0,1,3,0.
4. cfg_we=1, addr=1, data=111 with ch0 valid in the same cycle -> in_ready=0000. Next cycle ch0 x=1 from 00 -> state 11, z=1.
5. ch_clr[1]=1 while ch1 valid and ptr=1 -> ch2 granted; ch1 state_out=00, z_out[1]=0.
6. Assert reset during a granted cycle after a table rewrite -> next cycle all z_valid=0 and states 00. entry1 reads back 010, verified by a ch0 x=1 lookup giving state 01, z=0.
